// File: rtl/alu_md_pkg.sv
// Shared definitions for the execute-stage ALU with RV32M multiply/divide.
// Contents: base ALU op codes, M-extension funct3 codes, FSM state type,
//           and the shift-amount width helper.
package alu_md_pkg;

  // Base ALU op codes (op[4] == 0, code in op[3:0]).
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_SLT  = 4'b1100;
  localparam logic [3:0] ALU_SLTU = 4'b1110;

  // M-extension funct3 codes (op[4] == 1, funct3 in op[2:0]).
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  // Number of operand-B bits used as the shift amount.
  function automatic int shamt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/alu_div_iter.sv
// Restoring radix-2 divider on operand magnitudes, one quotient bit per cycle.
// Latency: start edge loads, DATA_WIDTH iteration edges, then done is high for
//          one cycle (corner cases: done the cycle after start). No backpressure:
//          the owner must consume quotient/remainder in the cycle done is high.
// Ports: clk, rst_n (async active-low), start/flush controls, is_signed,
//        dividend/divisor in; done, quotient, remainder out.
module alu_div_iter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  flush,
  input  logic                  is_signed,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder
);

  localparam int N  = DATA_WIDTH;
  localparam int CW = $clog2(N + 1);

  logic          run, corner_zero, corner_ovf, neg_q, neg_r;
  logic [CW-1:0] cnt;
  logic [N-1:0]  quo, rem, dvs, dvd;
  logic          a_neg, b_neg, div_zero, div_ovf;
  logic [N-1:0]  a_mag, b_mag;
  logic [N:0]    r_sh, diff;

  assign a_neg    = is_signed & dividend[N-1];
  assign b_neg    = is_signed & divisor[N-1];
  assign a_mag    = a_neg ? -dividend : dividend;
  assign b_mag    = b_neg ? -divisor : divisor;
  assign div_zero = (divisor == '0);
  assign div_ovf  = is_signed && (dividend == {1'b1, {(N-1){1'b0}}}) && (divisor == '1);

  // Partial remainder shifted left with the next dividend bit; the borrow
  // out of the trial subtraction (diff[N]) decides the quotient bit.
  assign r_sh = {rem, quo[N-1]};
  assign diff = r_sh - {1'b0, dvs};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run         <= 1'b0;
      cnt         <= '0;
      quo         <= '0;
      rem         <= '0;
      dvs         <= '0;
      dvd         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      corner_zero <= 1'b0;
      corner_ovf  <= 1'b0;
    end else if (flush) begin
      run <= 1'b0;
    end else if (start) begin
      run         <= 1'b1;
      cnt         <= (div_zero || div_ovf) ? '0 : CW'(N);
      quo         <= a_mag;
      rem         <= '0;
      dvs         <= b_mag;
      dvd         <= dividend;
      neg_q       <= a_neg ^ b_neg;
      neg_r       <= a_neg;
      corner_zero <= div_zero;
      corner_ovf  <= div_ovf;
    end else if (run) begin
      if (cnt == '0) begin
        run <= 1'b0;
      end else begin
        cnt <= cnt - 1'b1;
        if (!diff[N]) begin
          rem <= diff[N-1:0];
          quo <= {quo[N-2:0], 1'b1};
        end else begin
          rem <= r_sh[N-1:0];
          quo <= {quo[N-2:0], 1'b0};
        end
      end
    end
  end

  assign done = run && (cnt == '0);

  // Sign fix-up is applied on the way out, so the iteration stays unsigned.
  assign quotient  = corner_zero ? '1  : corner_ovf ? dvd : (neg_q ? -quo : quo);
  assign remainder = corner_zero ? dvd : corner_ovf ? '0  : (neg_r ? -rem : rem);

endmodule

// File: rtl/alu_md_unit.sv
// Execute-stage RV32 ALU with M-extension multiply/divide and valid/ready handshake.
// Latency: base ops 1 cycle, multiplies MUL_LAT, divides DATA_WIDTH+2 (corners 2).
// Backpressure: result held while out_valid && !out_ready; in_ready low until the
//               result drains (a new op may be accepted in the draining cycle).
// Ports: clk, rst_n, flush; in_valid/in_ready with op, data_rs1, source_2;
//        out_valid/out_ready with ALU_result; busy while not IDLE.
module alu_md_unit
  import alu_md_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MUL_LAT    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4:0]            op,
  input  logic [DATA_WIDTH-1:0] data_rs1,
  input  logic [DATA_WIDTH-1:0] source_2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] ALU_result,
  output logic                  busy
);

  localparam int N   = DATA_WIDTH;
  localparam int SHW = shamt_width(DATA_WIDTH);
  localparam logic [1:0] MUL_CNT_INIT = 2'(MUL_LAT > 1 ? MUL_LAT - 2 : 0);

  state_t         state, state_n, accept_state;
  logic           accept, is_div;
  logic [2:0]     f3_q;
  logic [1:0]     mul_cnt;
  logic [2*N-1:0] prod_q, prod_full, a_x, b_x;
  logic           a_sgn, b_sgn;
  logic [SHW-1:0] shamt;
  logic [N-1:0]   base_res, div_quo, div_rem;
  logic           div_done;

  assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
  assign accept    = in_valid && in_ready && !flush;
  assign is_div    = op[4] & op[2];
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // Base ALU, evaluated on the live inputs in the accept cycle.
  assign shamt = source_2[SHW-1:0];
  always_comb begin
    base_res = data_rs1 + source_2;
    case (op[3:0])
      ALU_SUB:  base_res = data_rs1 - source_2;
      ALU_AND:  base_res = data_rs1 & source_2;
      ALU_OR:   base_res = data_rs1 | source_2;
      ALU_XOR:  base_res = data_rs1 ^ source_2;
      ALU_SRL:  base_res = data_rs1 >> shamt;
      ALU_SLL:  base_res = data_rs1 << shamt;
      ALU_SRA:  base_res = $unsigned($signed(data_rs1) >>> shamt);
      ALU_SLT:  base_res = {{(N-1){1'b0}}, $signed(data_rs1) < $signed(source_2)};
      ALU_SLTU: base_res = {{(N-1){1'b0}}, data_rs1 < source_2};
      default:  base_res = data_rs1 + source_2;
    endcase
  end

  // Full 2N-bit product: sign-extending to 2N bits makes one unsigned
  // multiplier serve all four signedness combinations modulo 2^(2N).
  assign a_sgn     = ((op[2:0] == F3_MULH) || (op[2:0] == F3_MULHSU)) && data_rs1[N-1];
  assign b_sgn     = (op[2:0] == F3_MULH) && source_2[N-1];
  assign a_x       = {{N{a_sgn}}, data_rs1};
  assign b_x       = {{N{b_sgn}}, source_2};
  assign prod_full = a_x * b_x;

  function automatic logic [N-1:0] mul_pick(input logic [2*N-1:0] p, input logic [2:0] f3);
    return (f3 == F3_MUL) ? p[N-1:0] : p[2*N-1:N];
  endfunction

  alu_div_iter #(.DATA_WIDTH(N)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (accept && is_div),
    .flush     (flush),
    .is_signed (~op[0]),
    .dividend  (data_rs1),
    .divisor   (source_2),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_comb begin
    if (!op[4])          accept_state = DONE;
    else if (op[2])      accept_state = DIV;
    else if (MUL_LAT == 1) accept_state = DONE;
    else                 accept_state = MUL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (flush) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: if (accept) state_n = accept_state;
        MUL:  if (mul_cnt == '0) state_n = DONE;
        DIV:  if (div_done) state_n = DONE;
        DONE: if (out_ready) state_n = accept ? accept_state : IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ALU_result <= '0;
      f3_q       <= '0;
      prod_q     <= '0;
      mul_cnt    <= '0;
    end else if (flush) begin
      mul_cnt <= '0;
    end else if (accept) begin
      f3_q <= op[2:0];
      if (!op[4]) begin
        ALU_result <= base_res;
      end else if (!op[2]) begin
        if (MUL_LAT == 1) begin
          ALU_result <= mul_pick(prod_full, op[2:0]);
        end else begin
          prod_q  <= prod_full;
          mul_cnt <= MUL_CNT_INIT;
        end
      end
    end else if (state == MUL) begin
      if (mul_cnt == '0) ALU_result <= mul_pick(prod_q, f3_q);
      else               mul_cnt    <= mul_cnt - 1'b1;
    end else if (state == DIV && div_done) begin
      ALU_result <= f3_q[1] ? div_rem : div_quo;
    end
  end

endmodule

// File: doc/alu_md_unit.md
Name: alu_md_unit

Overview:
- Execute-stage arithmetic unit for the RV32 pipeline.
- Extends the base integer ALU with RV32M multiply and divide, and a registered valid/ready handshake so the operations can take multiple cycles.
- Base ops complete in 1 cycle, multiplies in MUL_LAT cycles, divides iterate one bit per cycle.
- Sits between ID/EX and EX/MEM; the hazard unit stalls on in_ready low and flushes via flush.

Parameters:
DATA_WIDTH, 32, operand/result width (even, >=8)
MUL_LAT, 2, multiply latency in cycles from accept to out_valid (1..4)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous kill of in-flight op (branch mispredict/trap)
in_valid  in  1  operands and op valid
in_ready  out  1  unit can accept this cycle
op  in  5  op[4]=0: base ALU code in op[3:0]; op[4]=1: M-op, funct3 in op[2:0]
data_rs1  in  DATA_WIDTH  operand A
source_2  in  DATA_WIDTH  operand B (rs2 or immediate)
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
ALU_result  out  DATA_WIDTH  result, held stable while out_valid && !out_ready
busy  out  1  state != IDLE

Behaviour:
- Reset (rst_n low, async): state=IDLE, out_valid=0, ALU_result=0, busy=0; counters/accumulators cleared.
- Base codes: 0010 add, 0110 sub, 0000 and, 0001 or, 0011 xor, 1000 srl, 1001 sll, 1010 sra, 1100 slt, 1110 sltu. Shift amount = source_2[log2(DATA_WIDTH)-1:0]. Undefined base codes execute as add.
- M funct3: 000 MUL (low), 001 MULH (s×s), 010 MULHSU (s×u), 011 MULHU (u×u), 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- Handshake: accept when in_valid && in_ready; in_ready = (state==IDLE) || (state==DONE && out_ready). Exactly one op in flight. Result is dropped only on out_valid && out_ready.
- States:
  - IDLE: on accept go to DONE (base), MUL, or DIV.
  - MUL: full 2N-bit signed/unsigned product, carried through a MUL_LAT-1 stage delay line; then DONE.
  - DIV: restoring radix-2 on magnitudes, N iterations, sign fix-up on exit; then DONE.
  - DONE: out_valid=1. On out_ready go to IDLE, or to the next op's state if a new op is accepted in the same cycle.
- Latency from accept cycle T to out_valid:
  - base: T+1
  - MUL*: T+MUL_LAT
  - DIV/REM normal: T+DATA_WIDTH+2
- Divide corner cases bypass iteration, out_valid at T+2:
  - divisor 0: quotient = all ones, remainder = dividend.
  - signed overflow (dividend = -2^(N-1), divisor = -1): quotient = dividend, remainder = 0.
- Signs:
  - quotient negative iff operand signs differ (signed ops).
  - remainder takes the dividend's sign.
- flush: highest priority after reset. Next state IDLE, out_valid=0, any accept in that cycle is ignored, in_ready=1 the following cycle.
- Operands and op are captured at accept; input changes afterwards have no effect.

Decomposition:
- Package alu_md_pkg holds:
  - the 4-bit base op localparams (ALU_ADD=4'b0010 …);
  - M funct3 localparams;
  - state enum {IDLE, MUL, DIV, DONE};
  - helper function for shift-amount width.
- Sub-module alu_div_iter (DATA_WIDTH): start, signed flag, operands → done, quotient, remainder. It owns the iteration counter and the corner-case bypass.

Test Plan:
- Base: add 7+5 -> 12 at T+1; sra 0x80000000 by 4 -> 0xF8000000; sltu 1 vs 0xFFFFFFFF -> 1; slt -> 0.
- MULH 0x80000000×0x80000000 -> 0x40000000 at T+2 (MUL_LAT=2); MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE; MUL same -> 1.
- DIV -7/2 -> -3 (0xFFFFFFFD) and REM -7/2 -> -1, out_valid at T+34; DIVU 100/7 -> 14, REMU 100/7 -> 2.
- Corner cases: DIV x/0 -> 0xFFFFFFFF, REM 13/0 -> 13, DIV 0x80000000/-1 -> 0x80000000, REM -> 0; each at T+2.
- Backpressure: out_ready held low 5 cycles -> ALU_result stable, in_ready=0; releasing out_ready with in_valid high accepts the next op in the same cycle.
- flush at iteration 10 of DIV -> out_valid never asserts, busy=0 next cycle. Async reset mid-MUL -> all outputs 0 immediately.
